// File: rtl/reg_bus_arbiter_pkg.sv
// reg_arb_pkg: shared types and limits for the register-bus arbiter.
//   NReqMax    : largest supported requester count
//   reg_req_t  : one requester's access (address, write data, write flag, byte enables)
//   resp_trk_t : response tracking for the single in-flight access
package reg_arb_pkg;

   localparam int unsigned NReqMax  = 8;
   localparam int unsigned OwnerW   = $clog2(NReqMax);
   // Widest address a requester slice may carry; narrower AW is zero-extended.
   localparam int unsigned AddrMaxW = 64;

   typedef struct packed {
      logic [AddrMaxW-1:0] addr;
      logic [31:0]         wdata;
      logic                we;
      logic [3:0]          be;
   } reg_req_t;

   typedef struct packed {
      logic              valid;
      logic              is_read;
      logic [OwnerW-1:0] owner;
   } resp_trk_t;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index; search runs upward from here with wrap
//   gnt_o : one-hot winner (all zero when no request)
//   idx_o : binary winner index (0 when no request)
module rr_pick #(
   parameter int unsigned NReq = 2,
   parameter int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
   input  logic [NReq-1:0] req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [NReq-1:0] gnt_o,
   output logic [IdxW-1:0] idx_o
);

   logic [IdxW-1:0] pos;
   logic            found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = ptr_i;
      for (int unsigned i = 0; i < NReq; i++) begin
         if (!found && req_i[pos]) begin
            found      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = pos;
         end
         // Explicit wrap so non-power-of-two NReq never visits a missing index.
         if (pos == IdxW'(NReq - 1)) begin
            pos = '0;
         end else begin
            pos = pos + IdxW'(1);
         end
      end
   end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of the peripheral register bus between
// NReq requesters, one access per cycle, read data routed back to its owner.
//   clk_i, rstn_i             : clock, asynchronous active-low reset
//   req_i/req_*_i             : per-requester request and access slices
//   gnt_o                     : one-hot, access of requester k accepted this cycle
//   rvalid_o, rdata_o         : one-hot response strobe and shared read data
//   reg_*_o / reg_*_i         : downstream slave port (accept = reg_en_o & reg_ready_i)
module reg_bus_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned NReq = 2,
   parameter int unsigned AW   = 32
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NReq-1:0]   req_i,
   input  logic [NReq*AW-1:0] req_addr_i,
   input  logic [NReq*32-1:0] req_wdata_i,
   input  logic [NReq-1:0]   req_we_i,
   input  logic [NReq*4-1:0] req_be_i,
   output logic [NReq-1:0]   gnt_o,
   output logic [NReq-1:0]   rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              reg_en_o,
   output logic [AW-1:0]     reg_addr_o,
   output logic [31:0]       reg_wdata_o,
   output logic              reg_we_o,
   output logic [3:0]        reg_be_o,
   input  logic [31:0]       reg_rdata_i,
   input  logic              reg_ready_i
);

   localparam int unsigned IdxW = $clog2(NReq);

   reg_req_t        reqs [NReq];
   reg_req_t        sel;
   logic [NReq-1:0] pick_gnt;
   logic [IdxW-1:0] pick_idx;
   logic [IdxW-1:0] win_idx;
   logic [IdxW-1:0] ptr_q;
   logic [IdxW-1:0] lock_idx_q;
   logic            lock_q;
   logic            accept;
   resp_trk_t       trk_q;
   logic            unused_sel_trk;

   for (genvar k = 0; k < NReq; k++) begin : g_slice
      assign reqs[k] = '{addr:  AddrMaxW'(req_addr_i[k*AW +: AW]),
                         wdata: req_wdata_i[k*32 +: 32],
                         we:    req_we_i[k],
                         be:    req_be_i[k*4 +: 4]};
   end

   rr_pick #(.NReq(NReq), .IdxW(IdxW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // A stalled access keeps the bus until accepted, ignoring new arrivals.
   assign win_idx = lock_q ? lock_idx_q : pick_idx;

   // Gated by rstn_i so the bus goes quiet the moment reset asserts.
   assign reg_en_o = rstn_i & (lock_q | (|req_i));
   assign accept   = reg_en_o & reg_ready_i;
   assign sel      = reg_en_o ? reqs[win_idx] : '0;

   assign reg_addr_o  = sel.addr[AW-1:0];
   assign reg_wdata_o = sel.wdata;
   assign reg_we_o    = sel.we;
   assign reg_be_o    = sel.be;

   always_comb begin
      gnt_o = '0;
      if (accept) begin
         gnt_o = lock_q ? (NReq'(1) << lock_idx_q) : pick_gnt;
      end
   end

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (trk_q.valid) begin
         rvalid_o = NReq'(1) << IdxW'(trk_q.owner);
         if (trk_q.is_read) begin
            rdata_o = reg_rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         trk_q      <= '0;
      end else begin
         if (accept) begin
            ptr_q  <= (win_idx == IdxW'(NReq - 1)) ? '0 : win_idx + IdxW'(1);
            lock_q <= 1'b0;
         end else if (reg_en_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= win_idx;
         end
         // Overwritten every cycle so a new acceptance coincides with the old response.
         trk_q.valid   <= accept;
         trk_q.is_read <= ~sel.we;
         trk_q.owner   <= OwnerW'(win_idx);
      end
   end

   assign unused_sel_trk = ^{sel.addr, trk_q.owner};

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;

   localparam int unsigned NReq = 2;
   localparam int unsigned AW   = 32;

   localparam logic [31:0] A0 = 32'h0400_0008;
   localparam logic [31:0] A1 = 32'h0400_0100;
   localparam logic [31:0] B1 = 32'h0400_0010;
   localparam logic [31:0] B2 = 32'h0400_0014;
   localparam logic [31:0] W0 = 32'hA0A0_0001;
   localparam logic [31:0] W1 = 32'h1234_5678;

   logic                clk = 1'b0;
   logic                rstn_i;
   logic [NReq-1:0]     req_i;
   logic [NReq*AW-1:0]  req_addr_i;
   logic [NReq*32-1:0]  req_wdata_i;
   logic [NReq-1:0]     req_we_i;
   logic [NReq*4-1:0]   req_be_i;
   logic [NReq-1:0]     gnt_o;
   logic [NReq-1:0]     rvalid_o;
   logic [31:0]         rdata_o;
   logic                reg_en_o;
   logic [AW-1:0]       reg_addr_o;
   logic [31:0]         reg_wdata_o;
   logic                reg_we_o;
   logic [3:0]          reg_be_o;
   logic [31:0]         reg_rdata_i;
   logic                reg_ready_i;

   logic [2:0] pk_req, pk_gnt;
   logic [1:0] pk_ptr, pk_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reg_bus_arbiter #(.NReq(NReq), .AW(AW)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn_i),
      .req_i       (req_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_we_i    (req_we_i),
      .req_be_i    (req_be_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .reg_en_o    (reg_en_o),
      .reg_addr_o  (reg_addr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_we_o    (reg_we_o),
      .reg_be_o    (reg_be_o),
      .reg_rdata_i (reg_rdata_i),
      .reg_ready_i (reg_ready_i)
   );

   rr_pick #(.NReq(3), .IdxW(2)) u_pick3 (
      .req_i (pk_req),
      .ptr_i (pk_ptr),
      .gnt_o (pk_gnt),
      .idx_o (pk_idx)
   );

   // Requesters must hold a stalled request until it is granted.
   always @(negedge clk) begin
      if (rstn_i && dut.lock_q) begin
         assert (req_i[dut.lock_idx_q])
            else $error("protocol: locked requester %0d dropped its request", dut.lock_idx_q);
      end
   end

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic        rdy;
      logic [31:0] rdin;
      logic [31:0] addr0;
      logic [1:0]  gnt;
      logic [1:0]  rv;
      logic [31:0] rd;
      logic        en;
      logic [31:0] addr;
      logic        ewe;
      logic [3:0]  ebe;
      logic [31:0] ewd;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic rdy,
                        input logic [31:0] rdin, input logic [31:0] addr0);
      req_i       = req;
      req_we_i    = we;
      reg_ready_i = rdy;
      reg_rdata_i = rdin;
      req_addr_i  = {A1, addr0};
      req_wdata_i = {W1, W0};
      req_be_i    = {4'h3, 4'hF};
   endtask

   initial begin
      logic [2:0] eg;
      logic [1:0] ei;
      int unsigned k;

      rstn_i = 1'b0;
      drive(2'b00, 2'b00, 1'b1, 32'h0, A0);
      pk_req = '0;
      pk_ptr = '0;

      //       req    we     rdy  rdin          addr0 | gnt    rv     rd            en   addr ewe ebe   ewd
      vq.push_back('{2'b01, 2'b00, 1'b1, 32'h0,        A0, 2'b01, 2'b00, 32'h0,        1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b00, 2'b00, 1'b1, 32'hDEADBEEF, A0, 2'b00, 2'b01, 32'hDEADBEEF, 1'b0, 0,  1'b0, 4'h0, 0});
      vq.push_back('{2'b10, 2'b00, 1'b1, 32'h55,       A0, 2'b10, 2'b00, 32'h0,        1'b1, A1, 1'b0, 4'h3, W1});
      vq.push_back('{2'b11, 2'b00, 1'b1, 32'h66,       A0, 2'b01, 2'b10, 32'h66,       1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b11, 2'b00, 1'b1, 32'h77,       A0, 2'b10, 2'b01, 32'h77,       1'b1, A1, 1'b0, 4'h3, W1});
      vq.push_back('{2'b11, 2'b00, 1'b1, 32'h88,       A0, 2'b01, 2'b10, 32'h88,       1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b11, 2'b00, 1'b1, 32'h99,       A0, 2'b10, 2'b01, 32'h99,       1'b1, A1, 1'b0, 4'h3, W1});
      vq.push_back('{2'b00, 2'b00, 1'b1, 32'hAA,       A0, 2'b00, 2'b10, 32'hAA,       1'b0, 0,  1'b0, 4'h0, 0});
      vq.push_back('{2'b01, 2'b01, 1'b1, 32'hBB,       A0, 2'b01, 2'b00, 32'h0,        1'b1, A0, 1'b1, 4'hF, W0});
      vq.push_back('{2'b01, 2'b00, 1'b0, 32'hCC,       A0, 2'b00, 2'b01, 32'h0,        1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        A0, 2'b00, 2'b00, 32'h0,        1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b11, 2'b00, 1'b0, 32'h0,        A0, 2'b00, 2'b00, 32'h0,        1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b11, 2'b00, 1'b1, 32'h0,        A0, 2'b01, 2'b00, 32'h0,        1'b1, A0, 1'b0, 4'hF, W0});
      vq.push_back('{2'b10, 2'b10, 1'b1, 32'hDD,       A0, 2'b10, 2'b01, 32'hDD,       1'b1, A1, 1'b1, 4'h3, W1});
      vq.push_back('{2'b00, 2'b00, 1'b1, 32'hEE,       A0, 2'b00, 2'b10, 32'h0,        1'b0, 0,  1'b0, 4'h0, 0});
      vq.push_back('{2'b01, 2'b00, 1'b1, 32'h0,        B1, 2'b01, 2'b00, 32'h0,        1'b1, B1, 1'b0, 4'hF, W0});
      vq.push_back('{2'b01, 2'b00, 1'b1, 32'h11,       B2, 2'b01, 2'b01, 32'h11,       1'b1, B2, 1'b0, 4'hF, W0});
      vq.push_back('{2'b00, 2'b00, 1'b1, 32'h22,       B2, 2'b00, 2'b01, 32'h22,       1'b0, 0,  1'b0, 4'h0, 0});

      // Reset state
      @(negedge clk);
      #1;
      check("rst_gnt",    32'(gnt_o),    32'h0);
      check("rst_rvalid", 32'(rvalid_o), 32'h0);
      check("rst_rdata",  rdata_o,       32'h0);
      check("rst_en",     32'(reg_en_o), 32'h0);
      check("rst_addr",   reg_addr_o,    32'h0);
      @(negedge clk);
      rstn_i = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].req, vq[i].we, vq[i].rdy, vq[i].rdin, vq[i].addr0);
         #1;
         check($sformatf("v%0d_gnt", i),    32'(gnt_o),       32'(vq[i].gnt));
         check($sformatf("v%0d_rvalid", i), 32'(rvalid_o),    32'(vq[i].rv));
         check($sformatf("v%0d_rdata", i),  rdata_o,          vq[i].rd);
         check($sformatf("v%0d_en", i),     32'(reg_en_o),    32'(vq[i].en));
         check($sformatf("v%0d_addr", i),   reg_addr_o,       vq[i].addr);
         check($sformatf("v%0d_we", i),     32'(reg_we_o),    32'(vq[i].ewe));
         check($sformatf("v%0d_be", i),     32'(reg_be_o),    32'(vq[i].ebe));
         check($sformatf("v%0d_wdata", i),  reg_wdata_o,      vq[i].ewd);
      end

      // Reset mid-access: pointer is 1 here, so a surviving pointer would pick requester 1 below.
      @(negedge clk);
      drive(2'b01, 2'b00, 1'b1, 32'h0, A0);
      #1;
      check("mid_gnt", 32'(gnt_o), 32'h1);
      @(negedge clk);
      rstn_i = 1'b0;
      drive(2'b01, 2'b00, 1'b1, 32'h3333, A0);
      #1;
      check("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
      check("mid_rst_rdata",  rdata_o,       32'h0);
      check("mid_rst_en",     32'(reg_en_o), 32'h0);
      check("mid_rst_gnt",    32'(gnt_o),    32'h0);
      check("mid_rst_addr",   reg_addr_o,    32'h0);
      @(negedge clk);
      rstn_i = 1'b1;
      drive(2'b11, 2'b00, 1'b1, 32'h4444, A0);
      #1;
      check("post_rst_rvalid", 32'(rvalid_o), 32'h0);
      check("post_rst_gnt",    32'(gnt_o),    32'h1);
      @(negedge clk);
      drive(2'b00, 2'b00, 1'b1, 32'h5555, A0);
      #1;
      check("post_rst_resp",  32'(rvalid_o), 32'h1);
      check("post_rst_rdata", rdata_o,       32'h5555);

      // Picker alone, three requesters: exercises the non-power-of-two wrap.
      for (int p = 0; p < 3; p++) begin
         for (int r = 0; r < 8; r++) begin
            pk_req = 3'(r);
            pk_ptr = 2'(p);
            eg = '0;
            ei = '0;
            for (int d = 0; d < 3; d++) begin
               k = unsigned'((p + d) % 3);
               if (eg == 3'b000 && pk_req[k]) begin
                  eg[k] = 1'b1;
                  ei    = 2'(k);
               end
            end
            #1;
            check($sformatf("pick_p%0d_r%0d", p, r), {27'h0, pk_gnt, pk_idx}, {27'h0, eg, ei});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Round-robin arbiter that shares the peripheral register bus of the TC device wrapper (PLIC, mmreg, CLINT, Ethernet MAC) between NReq requesters, for example the core data port and a debug/DMA master. It issues at most one access per cycle downstream and tracks which requester owns each in-flight access. It routes the one-cycle-delayed read data back to that owner only. It sits between the requesters and the wrapper's reg_* slave port.

Parameters:
NReq, 2, number of requesters (2..8)
AW, 32, address width

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
req_i  input  NReq  per-requester access request, held until granted
req_addr_i  input  NReq*AW  per-requester address, slice k = requester k
req_wdata_i  input  NReq*32  per-requester write data
req_we_i  input  NReq  1 = write, 0 = read
req_be_i  input  NReq*4  per-requester byte enables
gnt_o  output  NReq  one-hot; access of requester k accepted this cycle
rvalid_o  output  NReq  one-hot; response for requester k this cycle
rdata_o  output  32  read data, shared by all requesters, qualified by rvalid_o
reg_en_o  output  1  downstream access enable
reg_addr_o  output  AW  downstream address
reg_wdata_o  output  32  downstream write data
reg_we_o  output  1  downstream write enable
reg_be_o  output  4  downstream byte enables
reg_rdata_i  input  32  downstream read data, valid the cycle after acceptance
reg_ready_i  input  1  downstream ready; acceptance = reg_en_o & reg_ready_i

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, reg_en_o=0, all reg_* outputs 0. Priority pointer=0. Lock=0. Response-owner register invalid.
- Arbitration:
  - Combinational, on the same cycle a request is present.
  - Winner = first set bit of req_i, searching from the priority pointer upward with wrap-around.
  - reg_en_o = |req_i, or lock set.
  - reg_addr_o, reg_wdata_o, reg_we_o and reg_be_o = the winner's slices. They are 0 when reg_en_o=0.
- Acceptance:
  - gnt_o[w] = reg_en_o & reg_ready_i, for winner w.
  - On acceptance the pointer becomes (w+1) mod NReq.
  - Zero added latency: a request arriving at cycle t on an idle, ready bus is granted in cycle t.
- Stall:
  - If reg_en_o=1 and reg_ready_i=0, the lock is set and the current winner index is latched.
  - While locked, the arbiter keeps presenting that requester regardless of other req_i changes, including higher-priority arrivals.
  - The lock clears on acceptance.
  - Requesters must hold their request stable until granted. A request dropped while locked is a protocol violation; the bench asserts on it.
- Response tracking:
  - On acceptance, register owner=w, valid=1, and is_read=~we.
  - In the next cycle, rvalid_o[owner]=1.
  - rdata_o = reg_rdata_i for reads and 0 for writes. This is combinational from reg_rdata_i, so no additional latency.
  - rvalid_o=0 and rdata_o=0 when no response is pending.
- Back-to-back accesses: a new acceptance may occur in the same cycle as the previous access's response. The owner register simply updates, so full throughput of one access per cycle is sustained.
- Fairness: with all NReq requesters continuously requesting, each receives exactly one grant every NReq accepted cycles.
- Single requester: that requester is granted every cycle; the pointer still advances.
- Reset asserted mid-access: everything returns to its reset value immediately. Any pending response is dropped; no rvalid_o is issued after reset.
- Width rules:
  - Slice k of req_addr_i is bits [k*AW +: AW].
  - The winner index is $clog2(NReq) bits wide.
  - Pointer wrap uses an explicit compare to NReq-1, not a power-of-two mask.

Decomposition:
- Package reg_arb_pkg holds:
  - NReqMax=8;
  - typedef reg_req_t struct {addr, wdata, we, be};
  - typedef resp_trk_t struct {valid, is_read, owner}.
- One sub-module, rr_pick: a parameterised round-robin picker. Inputs are req vector and pointer; outputs are one-hot grant and binary index. It is purely combinational and unit-tested alone.

Test Plan:
- Single read: NReq=2. req_i=01, addr=0x0400_0008, reg_rdata_i=0xDEAD_BEEF next cycle -> gnt_o=01 in cycle 0; rvalid_o=01 and rdata_o=0xDEAD_BEEF in cycle 1.
- Contention: req_i=11 held for 4 cycles with pointer=0 -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later.
- Stall lock: req_i=01 with reg_ready_i=0 for 3 cycles; requester 1 raises its request in cycle 1 -> reg_addr_o stays at requester 0's address and gnt_o=00 throughout; when ready rises, gnt_o=01, then next gnt_o=10.
- Write response: requester 1 writes wdata=0x1234_5678 with be=0x3 -> downstream reg_we_o=1 and reg_be_o=0x3; next cycle rvalid_o=10 and rdata_o=0.
- Back-to-back reads: requester 0 reads addresses A and then B on consecutive cycles, with reg_rdata_i returning 0x11 then 0x22 -> rvalid_o=01 in both following cycles with rdata_o 0x11 then 0x22.
- Reset mid-access: drop rstn_i in the cycle after a granted read -> rvalid_o=0 and reg_en_o=0 immediately; the pointer is 0 after reset is released.
